awgn_sample_checker: RTL and testbench

Synthesizable on-chip consumer for the `awgn` output stream. It compares each generated sample against a golden sample held in an external synchronous ROM and counts sample mismatches and bit errors. It also captures the index of the first failing sample and reports pass/fail after a fixed-length run. It sits directly on `awgn_out`, giving hardware self-check of the generator without a simulation-only comparison.

---
 rtl/awgn_sample_checker.sv | 197 +++++++++++++++++++
 tb/tb_awgn_sample_checker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/awgn_sample_checker.sv
// awgn_sample_checker: compares each AWGN sample against a golden ROM and
// counts sample and bit mismatches over a fixed-length run.
// Pipeline: accept (register sample + index) -> compare against ROM data one
// cycle later -> counters / error pulse update at the following edge.
module awgn_sample_checker #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned NUM_SAMPLES = 10000,
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  sample_in,
    input  logic              sample_valid,
    output logic [ADDR_W-1:0] exp_addr,
    input  logic [WIDTH-1:0]  exp_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  sample_err_cnt,
    output logic [CNT_W-1:0]  bit_err_cnt,
    output logic [ADDR_W-1:0] first_err_idx,
    output logic              first_err_valid,
    output logic              err_pulse,
    output logic [ADDR_W-1:0] err_idx
);

    localparam int unsigned POP_W = $clog2(WIDTH + 1);
    // Adder wide enough for the counter plus a full-width popcount, with carry.
    localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_SAMPLES);
    localparam logic [CNT_W-1:0]  CntMax  = {CNT_W{1'b1}};
    localparam logic [SUM_W-1:0]  SumMax  = SUM_W'(CntMax);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    // The ROM address doubles as the 1-based sample index: both start at 1
    // and advance together on every accept.
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              cmp_v_q, cmp_v_d;
    logic [CNT_W-1:0]  sample_err_cnt_q, sample_err_cnt_d;
    logic [CNT_W-1:0]  bit_err_cnt_q, bit_err_cnt_d;
    logic [ADDR_W-1:0] first_err_idx_q, first_err_idx_d;
    logic              first_err_valid_q, first_err_valid_d;
    logic              err_pulse_q, err_pulse_d;
    logic [ADDR_W-1:0] err_idx_q, err_idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic [WIDTH-1:0]  diff;
    logic [POP_W-1:0]  pop;
    logic              mismatch;
    logic [SUM_W-1:0]  bit_sum;

    // Compare stage: XOR against ROM data and popcount the differing bits.
    always_comb begin
        diff = s_q ^ exp_data;
        pop  = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            pop = pop + POP_W'(diff[i]);
        end
        mismatch = cmp_v_q && (diff != '0);
        bit_sum  = SUM_W'(bit_err_cnt_q) + SUM_W'(pop);
    end

    // Next-state logic: compare-result bookkeeping first, then FSM control,
    // so a start clear overrides any stale compare.
    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        s_d               = s_q;
        idx_d             = idx_q;
        cmp_v_d           = 1'b0;
        sample_err_cnt_d  = sample_err_cnt_q;
        bit_err_cnt_d     = bit_err_cnt_q;
        first_err_idx_d   = first_err_idx_q;
        first_err_valid_d = first_err_valid_q;
        err_pulse_d       = 1'b0;
        err_idx_d         = err_idx_q;
        busy_d            = busy_q;
        done_d            = done_q;
        pass_d            = pass_q;

        if (mismatch) begin
            if (sample_err_cnt_q != CntMax) begin
                sample_err_cnt_d = sample_err_cnt_q + CNT_W'(1);
            end
            if (bit_sum > SumMax) begin
                bit_err_cnt_d = CntMax;
            end else begin
                bit_err_cnt_d = bit_sum[CNT_W-1:0];
            end
            err_pulse_d = 1'b1;
            err_idx_d   = idx_q;
            if (!first_err_valid_q) begin
                first_err_idx_d   = idx_q;
                first_err_valid_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d           = StRun;
                    addr_d            = ADDR_W'(1);
                    sample_err_cnt_d  = '0;
                    bit_err_cnt_d     = '0;
                    first_err_idx_d   = '0;
                    first_err_valid_d = 1'b0;
                    err_pulse_d       = 1'b0;
                    busy_d            = 1'b1;
                    done_d            = 1'b0;
                    pass_d            = 1'b0;
                end
            end
            StRun: begin
                if (sample_valid) begin
                    s_d     = sample_in;
                    idx_d   = addr_q;
                    cmp_v_d = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                    if (addr_q == LastIdx) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Final compare resolves this cycle; its count is in *_d.
                state_d = StDone;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (sample_err_cnt_d == '0);
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers, all cleared by asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= StIdle;
            addr_q            <= '0;
            s_q               <= '0;
            idx_q             <= '0;
            cmp_v_q           <= 1'b0;
            sample_err_cnt_q  <= '0;
            bit_err_cnt_q     <= '0;
            first_err_idx_q   <= '0;
            first_err_valid_q <= 1'b0;
            err_pulse_q       <= 1'b0;
            err_idx_q         <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            addr_q            <= addr_d;
            s_q               <= s_d;
            idx_q             <= idx_d;
            cmp_v_q           <= cmp_v_d;
            sample_err_cnt_q  <= sample_err_cnt_d;
            bit_err_cnt_q     <= bit_err_cnt_d;
            first_err_idx_q   <= first_err_idx_d;
            first_err_valid_q <= first_err_valid_d;
            err_pulse_q       <= err_pulse_d;
            err_idx_q         <= err_idx_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            pass_q            <= pass_d;
        end
    end

    assign exp_addr        = addr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign sample_err_cnt  = sample_err_cnt_q;
    assign bit_err_cnt     = bit_err_cnt_q;
    assign first_err_idx   = first_err_idx_q;
    assign first_err_valid = first_err_valid_q;
    assign err_pulse       = err_pulse_q;
    assign err_idx         = err_idx_q;

endmodule

// File: tb/tb_awgn_sample_checker.sv
// Bench for awgn_sample_checker: golden ROM mem[k]=k, scoreboard of expected
// error pulses, and end-of-run counter/pass checks on a default instance and
// a CNT_W=4 instance driven with identical stimulus.
module tb_awgn_sample_checker;

    localparam int N = 10000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;

    logic [13:0] exp_addr;
    logic [15:0] exp_data = '0;
    logic        busy, done, pass;
    logic [15:0] sample_err_cnt, bit_err_cnt;
    logic [13:0] first_err_idx;
    logic        first_err_valid, err_pulse;
    logic [13:0] err_idx;

    logic [13:0] s_exp_addr;
    logic [15:0] s_exp_data = '0;
    logic        s_busy, s_done, s_pass;
    logic [3:0]  s_sample_err_cnt, s_bit_err_cnt;
    logic [13:0] s_first_err_idx;
    logic        s_first_err_valid, s_err_pulse;
    logic [13:0] s_err_idx;

    awgn_sample_checker dut (
        .clk(clk), .rst(rst), .start(start), .sample_in(sample_in),
        .sample_valid(sample_valid), .exp_addr(exp_addr), .exp_data(exp_data),
        .busy(busy), .done(done), .pass(pass), .sample_err_cnt(sample_err_cnt),
        .bit_err_cnt(bit_err_cnt), .first_err_idx(first_err_idx),
        .first_err_valid(first_err_valid), .err_pulse(err_pulse), .err_idx(err_idx)
    );

    awgn_sample_checker #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .start(start), .sample_in(sample_in),
        .sample_valid(sample_valid), .exp_addr(s_exp_addr), .exp_data(s_exp_data),
        .busy(s_busy), .done(s_done), .pass(s_pass), .sample_err_cnt(s_sample_err_cnt),
        .bit_err_cnt(s_bit_err_cnt), .first_err_idx(s_first_err_idx),
        .first_err_valid(s_first_err_valid), .err_pulse(s_err_pulse), .err_idx(s_err_idx)
    );

    always #5 clk = ~clk;

    // Synchronous golden ROM, mem[k] = k.
    always @(posedge clk) begin
        exp_data   <= 16'(exp_addr);
        s_exp_data <= 16'(s_exp_addr);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        bit err;
        int idx;
    } sb_t;
    sb_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [15:0] gen_sample(input int mode, input int k);
        logic [15:0] v;
        v = 16'(k);
        if (mode == 1) begin
            if (k == 37)   v = v ^ 16'h0001;
            if (k == 9000) v = v ^ 16'h00F0;
        end else if (mode == 2) begin
            v = ~v;
        end
        return v;
    endfunction

    // One clock: drive inputs, take the edge, then check the error pulse
    // against the scoreboard entry due this cycle (if any).
    task automatic step(input logic v, input logic [15:0] d, input logic st);
        sb_t e;
        logic       want_pulse;
        int         want_idx;
        sample_valid = v;
        sample_in    = d;
        start        = st;
        @(posedge clk);
        #1;
        want_pulse = 1'b0;
        want_idx   = 0;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e          = sb_q.pop_front();
            want_pulse = e.err;
            want_idx   = e.idx;
        end
        check_eq("err_pulse", 32'(err_pulse), 32'(want_pulse));
        if (want_pulse) check_eq("err_idx", 32'(err_idx), want_idx);
        sample_valid = 1'b0;
        start        = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ":exp_addr"}, 32'(exp_addr), 0);
        check_eq({tag, ":busy"}, 32'(busy), 0);
        check_eq({tag, ":done"}, 32'(done), 0);
        check_eq({tag, ":pass"}, 32'(pass), 0);
        check_eq({tag, ":sample_err_cnt"}, 32'(sample_err_cnt), 0);
        check_eq({tag, ":bit_err_cnt"}, 32'(bit_err_cnt), 0);
        check_eq({tag, ":first_err_idx"}, 32'(first_err_idx), 0);
        check_eq({tag, ":first_err_valid"}, 32'(first_err_valid), 0);
        check_eq({tag, ":err_pulse"}, 32'(err_pulse), 0);
        check_eq({tag, ":err_idx"}, 32'(err_idx), 0);
        check_eq({tag, ":small_sample_err_cnt"}, 32'(s_sample_err_cnt), 0);
    endtask

    // mode: 0 clean, 1 errors at 37/9000, 2 all inverted.
    // gap: idle cycles after each accept. abort_at: reset before that sample.
    // start_at: pulse start together with that sample's accept.
    task automatic run_stream(input int mode, input int gap, input int abort_at,
                              input int start_at);
        int          serr;
        int          berr;
        int          first;
        logic [15:0] d;
        serr  = 0;
        berr  = 0;
        first = 0;

        step(1'b0, 16'h0, 1'b1);
        check_eq("start:busy", 32'(busy), 1);
        check_eq("start:done", 32'(done), 0);
        check_eq("start:pass", 32'(pass), 0);
        check_eq("start:exp_addr", 32'(exp_addr), 1);
        check_eq("start:sample_err_cnt", 32'(sample_err_cnt), 0);
        check_eq("start:bit_err_cnt", 32'(bit_err_cnt), 0);
        check_eq("start:first_err_valid", 32'(first_err_valid), 0);
        check_eq("start:first_err_idx", 32'(first_err_idx), 0);

        for (int k = 1; k <= N; k++) begin
            if (k == abort_at) begin
                #2 rst = 1'b1;
                #1 check_all_zero("midreset");
                @(posedge clk);
                #1 rst = 1'b0;
                sb_q.delete();
                return;
            end
            d = gen_sample(mode, k);
            if (d != 16'(k)) begin
                serr++;
                berr += $countones(d ^ 16'(k));
                if (first == 0) first = k;
            end
            sb_q.push_back('{due: cyc + 2, err: (d != 16'(k)), idx: k});
            step(1'b1, d, (k == start_at));
            check_eq("exp_addr", 32'(exp_addr), k + 1);
            check_eq("busy", 32'(busy), 1);
            if (k < N) begin
                for (int g = 0; g < gap; g++) begin
                    step(1'b0, 16'($urandom), 1'b0);
                    check_eq("gap:exp_addr", 32'(exp_addr), k + 1);
                end
            end
        end
        // In DRAIN after the last accept.
        check_eq("drain:done", 32'(done), 0);
        step(1'b0, 16'h0, 1'b0);
        check_eq("end:done", 32'(done), 1);
        check_eq("end:busy", 32'(busy), 0);
        check_eq("end:pass", 32'(pass), 32'(serr == 0));
        check_eq("end:sample_err_cnt", 32'(sample_err_cnt), sat(serr, 65535));
        check_eq("end:bit_err_cnt", 32'(bit_err_cnt), sat(berr, 65535));
        check_eq("end:first_err_valid", 32'(first_err_valid), 32'(first != 0));
        check_eq("end:first_err_idx", 32'(first_err_idx), first);
        check_eq("end:small_sample_err_cnt", 32'(s_sample_err_cnt), sat(serr, 15));
        check_eq("end:small_bit_err_cnt", 32'(s_bit_err_cnt), sat(berr, 15));
        check_eq("end:small_done", 32'(s_done), 1);
        check_eq("end:sb_empty", 32'(sb_q.size()), 0);
        // DONE holds.
        step(1'b0, 16'h0, 1'b0);
        check_eq("hold:done", 32'(done), 1);
        check_eq("hold:pass", 32'(pass), 32'(serr == 0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst = 1'b0;
        step(1'b0, 16'h0, 1'b0);
        check_all_zero("idle");

        run_stream(0, 0, 0, 0);     // clean back-to-back
        run_stream(2, 0, 0, 0);     // all inverted: saturation
        run_stream(1, 0, 0, 5000);  // two errors, start ignored in RUN
        run_stream(0, 2, 0, 0);     // gapped valid, clean
        run_stream(1, 0, 500, 0);   // reset mid-run
        run_stream(0, 0, 0, 0);     // clean run after reset

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
